// File: rtl/vedic_pkg.sv
// Shared types and helpers for the sequential Vedic multiplier.
//   state_e      : controller states (IDLE, CALC, DONE)
//   DIGIT_W      : digit width consumed by the 2x2 core per cycle
//   digit_count(): number of digits per operand for a given width
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DIGIT_W = 2;

    function automatic int unsigned digit_count(input int unsigned width);
        return width / DIGIT_W;
    endfunction

endpackage

// File: rtl/vedic_2x2_core.sv
// Combinational 2x2 Urdhva-Tiryakbhyam multiplier digit core.
//   a_i : 2-bit multiplicand digit
//   b_i : 2-bit multiplier digit
//   p_o : 4-bit product a_i*b_i (0..9)
module vedic_2x2_core (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);

    logic a0b0;
    logic a1b0;
    logic a0b1;
    logic a1b1;
    logic c1;

    assign a0b0 = a_i[0] & b_i[0];
    assign a1b0 = a_i[1] & b_i[0];
    assign a0b1 = a_i[0] & b_i[1];
    assign a1b1 = a_i[1] & b_i[1];

    // Carry out of the cross-product column feeds the top column.
    assign c1  = a1b0 & a0b1;
    assign p_o = {a1b1 & c1, a1b1 ^ c1, a1b0 ^ a0b1, a0b0};

endmodule

// File: rtl/vedic_seq_mult.sv
// Sequential WIDTH x WIDTH unsigned multiplier: one 2x2 digit pair per cycle
// through a shared Vedic core, shifted partial products accumulated.
//   clk, rst_n           : clock, async active-low reset
//   in_valid, in_ready   : operand handshake (a, b)
//   out_valid, out_ready : product handshake (product = a*b)
//   busy                 : high while computing or holding a result
module vedic_seq_mult
    import vedic_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int unsigned D     = digit_count(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned SH_W  = $clog2(PW);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(D - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    product_q;
    logic [IDX_W-1:0] i_q;
    logic [IDX_W-1:0] j_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             in_ready_q;

    logic [DIGIT_W-1:0] da;
    logic [DIGIT_W-1:0] db;
    logic [3:0]         pp;
    logic [SH_W-1:0]    sh;
    logic [PW-1:0]      acc_d;

    // Current digit pair selected from the registered operands.
    assign da = a_q[DIGIT_W*i_q +: DIGIT_W];
    assign db = b_q[DIGIT_W*j_q +: DIGIT_W];

    vedic_2x2_core u_core (
        .a_i (da),
        .b_i (db),
        .p_o (pp)
    );

    // Digit pair (i,j) has weight 4^(i+j); max shift 2*WIDTH-4 fits the accumulator.
    assign sh    = SH_W'(DIGIT_W * (int'(i_q) + int'(j_q)));
    assign acc_d = acc_q + (PW'(pp) << sh);

    // Controller: state, digit indices, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            i_q         <= '0;
            j_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        acc_q      <= '0;
                        i_q        <= '0;
                        j_q        <= '0;
                        state_q    <= CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        if (i_q == LAST) begin
                            i_q         <= '0;
                            product_q   <= acc_d;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            i_q <= i_q + IDX_W'(1);
                        end
                    end else begin
                        j_q <= j_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_vedic_seq_mult.sv
// Bench for vedic_seq_mult: exhaustive 2x2 core check, directed handshake /
// latency / reset cases at WIDTH=8, and randomized streams at WIDTH=8 and 16
// compared against a queue of plain a*b products.
module tb_vedic_seq_mult;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Standalone core
    logic [1:0] ca = '0;
    logic [1:0] cb = '0;
    logic [3:0] cp;

    vedic_2x2_core u_core (
        .a_i (ca),
        .b_i (cb),
        .p_o (cp)
    );

    // WIDTH=8 instance
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [7:0]  a         = '0;
    logic [7:0]  b         = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    vedic_seq_mult #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // WIDTH=16 instance
    logic        rst16_n = 1'b0;
    logic        iv16    = 1'b0;
    logic        ir16;
    logic [15:0] a16     = '0;
    logic [15:0] b16     = '0;
    logic        ov16;
    logic        or16    = 1'b0;
    logic [31:0] p16;
    logic        busy16;

    vedic_seq_mult #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst16_n),
        .in_valid  (iv16),
        .in_ready  (ir16),
        .a         (a16),
        .b         (b16),
        .out_valid (ov16),
        .out_ready (or16),
        .product   (p16),
        .busy      (busy16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One WIDTH=8 transaction: latency, product, optional stall and input disturbance.
    task automatic do_txn(input logic [7:0] av, input logic [7:0] bv, input int hold, input bit disturb);
        int cnt;
        logic [15:0] exp;
        exp = 16'(av) * 16'(bv);
        @(negedge clk);
        check("acc_inrdy", 64'(in_ready), 64'd1);
        a = av; b = bv; in_valid = 1'b1; out_ready = (hold == 0);
        @(negedge clk);
        in_valid = 1'b0;
        check("calc_busy", 64'(busy), 64'd1);
        check("calc_inrdy", 64'(in_ready), 64'd0);
        cnt = 0;
        while (!out_valid && cnt < 200) begin
            if (disturb) begin
                a = 8'($urandom); b = 8'($urandom); in_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b0;
        check("latency", 64'(cnt), 64'd16);
        check("product", 64'(product), 64'(exp));
        for (int k = 0; k < hold; k++) begin
            check("hold_prod", 64'(product), 64'(exp));
            check("hold_ov", 64'(out_valid), 64'd1);
            check("hold_inrdy", 64'(in_ready), 64'd0);
            a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
            @(negedge clk);
        end
        if (hold > 0) check("hold_prod_end", 64'(product), 64'(exp));
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("exit_ov", 64'(out_valid), 64'd0);
        check("exit_inrdy", 64'(in_ready), 64'd1);
        check("exit_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        fork
            begin : main8
                int acc_n;
                int got_n;
                int cyc;
                logic [15:0] q8[$];

                for (int i = 0; i < 16; i++) begin
                    ca = 2'(i >> 2); cb = 2'(i);
                    #1;
                    check("core", 64'(cp), 64'(4'(ca) * 4'(cb)));
                end

                repeat (3) @(negedge clk);
                check("rst_inrdy", 64'(in_ready), 64'd1);
                check("rst_ov", 64'(out_valid), 64'd0);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_prod", 64'(product), 64'd0);
                rst_n = 1'b1;

                do_txn(8'h03, 8'h03, 0, 1'b0);
                do_txn(8'hFF, 8'hFF, 0, 1'b0);
                do_txn(8'h00, 8'hFF, 0, 1'b0);
                do_txn(8'hA5, 8'h3C, 5, 1'b0);
                do_txn(8'h5A, 8'hC3, 0, 1'b1);

                // Reset in the middle of a computation
                @(negedge clk);
                a = 8'h77; b = 8'h99; in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
                repeat (6) @(negedge clk);
                check("mid_busy", 64'(busy), 64'd1);
                rst_n = 1'b0;
                #1;
                check("mrst_ov", 64'(out_valid), 64'd0);
                check("mrst_prod", 64'(product), 64'd0);
                check("mrst_busy", 64'(busy), 64'd0);
                check("mrst_inrdy", 64'(in_ready), 64'd1);
                @(negedge clk);
                rst_n = 1'b1;
                do_txn(8'h12, 8'h34, 0, 1'b0);

                // Random stream, random backpressure
                acc_n = 0; got_n = 0; cyc = 0;
                while ((acc_n < 1000 || q8.size() > 0) && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    in_valid  = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
                    a = 8'($urandom); b = 8'($urandom);
                    if (in_valid && in_ready) begin
                        q8.push_back(16'(a) * 16'(b));
                        acc_n++;
                    end
                    if (out_valid && out_ready) begin
                        if (q8.size() == 0) check("r8_extra", 64'd1, 64'd0);
                        else check("r8_prod", 64'(product), 64'(q8.pop_front()));
                        got_n++;
                    end
                end
                in_valid = 1'b0;
                check("r8_count", 64'(got_n), 64'd1000);
                check("r8_drain", 64'(q8.size()), 64'd0);
            end
            begin : rand16
                int acc_n;
                int got_n;
                int cyc;
                logic [31:0] q16[$];

                repeat (3) @(negedge clk);
                check("r16_rst_inrdy", 64'(ir16), 64'd1);
                check("r16_rst_prod", 64'(p16), 64'd0);
                rst16_n = 1'b1;
                acc_n = 0; got_n = 0; cyc = 0;
                while ((acc_n < 300 || q16.size() > 0) && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    or16 = 1'($urandom_range(0, 1));
                    iv16 = (acc_n < 300) && ($urandom_range(0, 3) != 0);
                    a16 = 16'($urandom); b16 = 16'($urandom);
                    if (iv16 && ir16) begin
                        q16.push_back(32'(a16) * 32'(b16));
                        acc_n++;
                    end
                    if (ov16 && or16) begin
                        if (q16.size() == 0) check("r16_extra", 64'd1, 64'd0);
                        else check("r16_prod", 64'(p16), 64'(q16.pop_front()));
                        got_n++;
                    end
                end
                iv16 = 1'b0;
                check("r16_count", 64'(got_n), 64'd300);
                check("r16_drain", 64'(q16.size()), 64'd0);
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
